// File: rtl/d_latch_write_sequencer.sv
// d_latch_write_sequencer: valid/ready write controller producing a registered setup/enable/hold sequence for a D latch
module d_latch_write_sequencer #(
  parameter int WIDTH     = 1,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] d_out,
  output logic             en_out,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;
  localparam logic [7:0] S_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] P_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] H_LD = 8'(HOLD_CYC - 1);
  state_t     state;
  logic [7:0] cnt;
  assign wr_ready = state == IDLE;
  // d_out moves only on accept and en_out only on SETUP->OPEN / OPEN->HOLD, so they never switch on the same edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      d_out  <= '0;
      en_out <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (wr_valid) begin
            d_out <= wr_data;
            cnt   <= S_LD;
            state <= SETUP;
          end
        SETUP:
          if (cnt == 8'd0) begin
            state  <= OPEN;
            cnt    <= P_LD;
            en_out <= 1'b1;
          end else cnt <= cnt - 8'd1;
        OPEN:
          if (cnt == 8'd0) begin
            state  <= HOLD;
            cnt    <= H_LD;
            en_out <= 1'b0;
          end else cnt <= cnt - 8'd1;
        HOLD:
          if (cnt == 8'd0) begin
            state <= IDLE;
            done  <= 1'b1;
          end else cnt <= cnt - 8'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_d_latch_write_sequencer.sv
// tb_d_latch_write_sequencer: table-driven vectors plus directed reset and parameter-sweep sequences
module tb_d_latch_write_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, wr_valid = 1'b0;
  logic [3:0] wr_data = '0;
  logic rdy_a, en_a, dn_a, rdy_b, en_b, dn_b, rdy_c, en_c, dn_c;
  logic [3:0] d_a, d_b, d_c, q;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  d_latch_write_sequencer #(.WIDTH(4)) dut_a (.clk(clk), .rst_n(rst_n), .wr_valid(wr_valid),
    .wr_ready(rdy_a), .wr_data(wr_data), .d_out(d_a), .en_out(en_a), .done(dn_a));
  d_latch_write_sequencer #(.WIDTH(4), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(4)) dut_b (.clk(clk),
    .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(rdy_b), .wr_data(wr_data), .d_out(d_b),
    .en_out(en_b), .done(dn_b));
  d_latch_write_sequencer #(.WIDTH(4), .SETUP_CYC(1), .PULSE_CYC(5), .HOLD_CYC(1)) dut_c (.clk(clk),
    .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(rdy_c), .wr_data(wr_data), .d_out(d_c),
    .en_out(en_c), .done(dn_c));

  always_latch if (en_a) q <= d_a;

  typedef struct {
    logic       v;
    logic [3:0] data;
    logic       rdy;
    logic       en;
    logic [3:0] d;
    logic       dn;
    logic       qc;
    logic [3:0] q;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [3:0] data, input logic rdy, input logic en,
                     input logic [3:0] d, input logic dn, input logic qc, input logic [3:0] qv);
    vec_t t;
    t.v = v; t.data = data; t.rdy = rdy; t.en = en; t.d = d; t.dn = dn; t.qc = qc; t.q = qv;
    vecs.push_back(t);
  endtask

  initial begin
    int en_first[3], en_w[3], dn_first[3];
    logic [2:0] en_s, dn_s;
    bit ok;
    // single write of A
    add(1, 4'hA, 0, 0, 4'hA, 0, 0, 4'h0);
    add(0, 4'h0, 0, 1, 4'hA, 0, 1, 4'hA);
    add(0, 4'h0, 0, 1, 4'hA, 0, 1, 4'hA);
    add(0, 4'h0, 0, 0, 4'hA, 0, 1, 4'hA);
    add(0, 4'h0, 1, 0, 4'hA, 1, 1, 4'hA);
    add(0, 4'h0, 1, 0, 4'hA, 0, 1, 4'hA);
    // busy-ignore: F and valid toggles while busy must not be taken
    add(1, 4'h5, 0, 0, 4'h5, 0, 1, 4'hA);
    add(0, 4'hF, 0, 1, 4'h5, 0, 1, 4'h5);
    add(1, 4'hF, 0, 1, 4'h5, 0, 1, 4'h5);
    add(0, 4'hF, 0, 0, 4'h5, 0, 1, 4'h5);
    add(1, 4'hF, 1, 0, 4'h5, 1, 1, 4'h5);
    add(0, 4'hF, 1, 0, 4'h5, 0, 1, 4'h5);
    // back-to-back 3 then C with valid held
    add(1, 4'h3, 0, 0, 4'h3, 0, 1, 4'h5);
    add(1, 4'hC, 0, 1, 4'h3, 0, 1, 4'h3);
    add(1, 4'hC, 0, 1, 4'h3, 0, 1, 4'h3);
    add(1, 4'hC, 0, 0, 4'h3, 0, 1, 4'h3);
    add(1, 4'hC, 1, 0, 4'h3, 1, 1, 4'h3);
    add(1, 4'hC, 0, 0, 4'hC, 0, 1, 4'h3);
    add(0, 4'h0, 0, 1, 4'hC, 0, 1, 4'hC);
    add(0, 4'h0, 0, 1, 4'hC, 0, 1, 4'hC);
    add(0, 4'h0, 0, 0, 4'hC, 0, 1, 4'hC);
    add(0, 4'h0, 1, 0, 4'hC, 1, 1, 4'hC);
    add(0, 4'h0, 1, 0, 4'hC, 0, 1, 4'hC);

    // reset state, then 10 idle cycles with no output change
    #12;
    chk("rst_ready", rdy_a, 1); chk("rst_en", en_a, 0); chk("rst_d", d_a, 0); chk("rst_done", dn_a, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("idle_%0d", i), {rdy_a, en_a, dn_a, d_a}, 7'b1000000);
    end

    foreach (vecs[i]) begin
      @(negedge clk);
      wr_valid = vecs[i].v; wr_data = vecs[i].data;
      @(posedge clk); #1;
      chk($sformatf("v%0d_ready", i), rdy_a, vecs[i].rdy);
      chk($sformatf("v%0d_en", i), en_a, vecs[i].en);
      chk($sformatf("v%0d_d", i), d_a, vecs[i].d);
      chk($sformatf("v%0d_done", i), dn_a, vecs[i].dn);
      if (vecs[i].qc) chk($sformatf("v%0d_q", i), q, vecs[i].q);
    end

    // reset mid-OPEN: en_out must drop without a clock edge
    @(negedge clk) wr_valid = 1'b1; wr_data = 4'h6;
    @(negedge clk) wr_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_en", en_a, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_en", en_a, 0); chk("async_d", d_a, 0); chk("async_ready", rdy_a, 1);
    @(negedge clk) rst_n = 1'b1; wr_valid = 1'b1; wr_data = 4'h9;
    @(negedge clk) wr_valid = 1'b0;
    chk("post_rst_d", d_a, 4'h9);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk); #1;
      ok = dn_a;
    end
    chk("post_rst_done", ok, 1);

    // parameter sweep: all three instances accept on the same edge
    @(negedge clk) wr_valid = 1'b0;
    repeat (15) @(negedge clk);
    en_first = '{-1, -1, -1}; dn_first = '{-1, -1, -1}; en_w = '{0, 0, 0};
    wr_valid = 1'b1; wr_data = 4'h7;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (k == 0) wr_valid = 1'b0;
      en_s = {en_c, en_b, en_a}; dn_s = {dn_c, dn_b, dn_a};
      for (int j = 0; j < 3; j++) begin
        if (en_s[j]) en_w[j]++;
        if (en_s[j] && en_first[j] < 0) en_first[j] = k;
        if (dn_s[j] && dn_first[j] < 0) dn_first[j] = k;
      end
    end
    chk("a_setup", en_first[0], 1); chk("a_width", en_w[0], 2); chk("a_done", dn_first[0], 4);
    chk("b_setup", en_first[1], 3); chk("b_width", en_w[1], 1); chk("b_done", dn_first[1], 8);
    chk("c_setup", en_first[2], 1); chk("c_width", en_w[2], 5); chk("c_done", dn_first[2], 7);
    chk("b_d", d_b, 4'h7); chk("c_d", d_c, 4'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
